// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
//   Shared AXI4-Lite definitions for the write/read-back checker:
//   response codes, the checker state encoding and a response helper.
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } axi_state_e;

  // Only a plain OKAY counts as success. EXOKAY is meaningless for a
  // non-exclusive AXI4-Lite access, so it is treated as a failure as well.
  function automatic logic resp_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_lite_wr_rd_checker.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_rd_checker
//   AXI4-Lite master for on-board self-test of a register slave. A rising edge
//   on INIT_AXI_TXN writes C_M_TRANSACTIONS_NUM words (START, START+1, ...) to
//   consecutive word addresses starting at the slave base, reading each word
//   back right after it is written and comparing it with the value written.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN : clock, synchronous active-low reset
//   INIT_AXI_TXN              : start request (rising edge)
//   TXN_DONE                  : sticky, all vectors finished
//   ERROR                     : sticky, any data mismatch or non-OKAY response
//   M_AXI_AW* / W* / B*       : write address, write data, write response
//   M_AXI_AR* / R*            : read address, read data
// -----------------------------------------------------------------------------
module axi_lite_wr_rd_checker
  import axi_lite_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH         = 32,
  parameter int                            C_M_AXI_DATA_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h43C00000,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_M_START_DATA_VALUE       = 32'hAA000000,
  parameter int                            C_M_TRANSACTIONS_NUM       = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            INIT_AXI_TXN,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  // Five bits cover the full 1..16 vector range.
  localparam int                IDX_W    = 5;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(C_M_TRANSACTIONS_NUM - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_M_AXI_ADDR_WIDTH'(4);
  localparam logic [C_M_AXI_DATA_WIDTH-1:0] DATA_STEP = C_M_AXI_DATA_WIDTH'(1);

  axi_state_e                      r_state;
  axi_state_e                      w_next_state;

  logic                            r_init_q;
  logic [IDX_W-1:0]                r_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_arvalid;
  logic                            r_aw_done;
  logic                            r_w_done;
  logic                            r_error;

  logic                            w_start_pulse;
  logic                            w_aw_fin;
  logic                            w_w_fin;
  logic                            w_last;
  logic                            w_bready;
  logic                            w_rready;

  assign w_start_pulse = INIT_AXI_TXN & ~r_init_q;

  // A channel counts as finished once its handshake has happened, including
  // a handshake landing on this very edge. This lets AW and W complete in
  // either order or together without issuing a second beat.
  assign w_aw_fin = r_aw_done | (r_awvalid & M_AXI_AWREADY);
  assign w_w_fin  = r_w_done  | (r_wvalid  & M_AXI_WREADY);
  assign w_last   = (r_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and response-channel ready decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_bready     = 1'b0;
    w_rready     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_start_pulse) begin
          w_next_state = WR;
        end
      end
      WR: begin
        if (w_aw_fin && w_w_fin) begin
          w_next_state = WRESP;
        end
      end
      WRESP: begin
        w_bready = 1'b1;
        if (M_AXI_BVALID) begin
          w_next_state = RADDR;
        end
      end
      RADDR: begin
        if (r_arvalid && M_AXI_ARREADY) begin
          w_next_state = RDATA;
        end
      end
      RDATA: begin
        w_rready = 1'b1;
        if (M_AXI_RVALID) begin
          w_next_state = w_last ? DONE : WR;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request channels, vector generator and error tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_init_q  <= 1'b0;
      r_idx     <= '0;
      r_awaddr  <= C_M_TARGET_SLAVE_BASE_ADDR;
      r_araddr  <= C_M_TARGET_SLAVE_BASE_ADDR;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_init_q <= INIT_AXI_TXN;
      case (r_state)
        IDLE, DONE: begin
          if (w_start_pulse) begin
            r_error  <= 1'b0;
            r_idx    <= '0;
            r_awaddr <= C_M_TARGET_SLAVE_BASE_ADDR;
            r_araddr <= C_M_TARGET_SLAVE_BASE_ADDR;
            r_wdata  <= C_M_START_DATA_VALUE;
          end
        end
        WR: begin
          // VALID is raised on the first WR cycle without looking at READY
          // and dropped on the edge of its own handshake.
          if (!r_awvalid && !r_aw_done) begin
            r_awvalid <= 1'b1;
          end else if (r_awvalid && M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (!r_wvalid && !r_w_done) begin
            r_wvalid <= 1'b1;
          end else if (r_wvalid && M_AXI_WREADY) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Leaving WR re-arms both channels for the next vector.
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID && !resp_ok(M_AXI_BRESP)) begin
            r_error <= 1'b1;
          end
        end
        RADDR: begin
          if (!r_arvalid) begin
            r_arvalid <= 1'b1;
          end else if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
          end
        end
        RDATA: begin
          if (M_AXI_RVALID) begin
            if ((M_AXI_RDATA != r_wdata) || !resp_ok(M_AXI_RRESP)) begin
              r_error <= 1'b1;
            end
            // Errors never cut the run short; every vector is exercised.
            if (!w_last) begin
              r_idx    <= r_idx + IDX_W'(1);
              r_awaddr <= r_awaddr + ADDR_STEP;
              r_araddr <= r_araddr + ADDR_STEP;
              r_wdata  <= r_wdata + DATA_STEP;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign TXN_DONE      = (r_state == DONE);
  assign ERROR         = r_error;

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = w_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = w_rready;

endmodule
